// File: rtl/io_seg7_pkg.sv
// rtl/io_seg7_pkg.sv - shared types, defaults and width helpers for the seven-segment scanner
package io_seg7_pkg;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_e;

  localparam int DIGITS_DEF  = 4;
  localparam int CLK_DIV_DEF = 50000;
  localparam int DEAD_DEF    = 500;
  localparam int MAX_DIGITS  = 8;

  localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = '1;

  function automatic int cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  function automatic int idx_width(input int digits);
    return (digits < 2) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/io_seg7_prescale.sv
// rtl/io_seg7_prescale.sv - free-running slot divider with wrap and dead-end pulses
module io_seg7_prescale
  import io_seg7_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int DEAD    = DEAD_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic wrap,
  output logic dead_end
);

  localparam int CNT_W = cnt_width(CLK_DIV);

  logic [CNT_W-1:0] cnt;

  assign wrap     = (cnt == CNT_W'(CLK_DIV - 1));
  assign dead_end = (cnt == CNT_W'(DEAD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/io_seg7_scan.sv
// rtl/io_seg7_scan.sv - multiplexed common-anode digit scanner with shadow/display buffering
// Optional leading-zero blanking when SEG7_SCAN_LZB_EN is defined.
module io_seg7_scan
  import io_seg7_pkg::*;
#(
  parameter int DIGITS  = DIGITS_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int DEAD    = DEAD_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   val_in,
  input  logic                  val_load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank,
  output logic [3:0]            digit_nib,
  output logic [DIGITS-1:0]     digit_an,
  output logic                  digit_dp,
  output logic                  frame_start
);

  localparam int IDX_W = idx_width(DIGITS);
  localparam int VAL_W = 4 * DIGITS;

  logic [VAL_W-1:0]  shadow_val, disp_val, disp_val_next;
  logic [DIGITS-1:0] shadow_dp, disp_dp, disp_dp_next;
  logic [IDX_W-1:0]  idx, idx_next;
  scan_state_e       state, state_next;
  logic              wrap, dead_end, hide;
  logic [DIGITS-1:0] an_next;

  io_seg7_prescale #(
    .CLK_DIV (CLK_DIV),
    .DEAD    (DEAD)
  ) u_prescale (
    .clk      (clk),
    .reset    (reset),
    .wrap     (wrap),
    .dead_end (dead_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (val_load) begin
      shadow_val <= val_in;
      shadow_dp  <= dp_in;
    end
  end

  // The display copy uses the pre-load shadow, so a load on the boundary lands one frame later.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    disp_val_next = disp_val;
    disp_dp_next  = disp_dp;
    if (wrap) begin
      state_next = ST_DEAD;
      idx_next   = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      if (idx_next == '0) begin
        disp_val_next = shadow_val;
        disp_dp_next  = shadow_dp;
      end
    end else if (state == ST_DEAD && dead_end) begin
      state_next = ST_SHOW;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_DEAD;
      idx      <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      disp_val <= disp_val_next;
      disp_dp  <= disp_dp_next;
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  always_comb begin
    hide = (idx != '0) && !disp_dp[idx] && ((disp_val >> {idx, 2'b00}) == '0);
  end
`else
  assign hide = 1'b0;
`endif

  always_comb begin
    an_next = '1;
    if (state_next == ST_SHOW && !blank && !hide) begin
      an_next = ~(DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_an    <= AN_ALL_OFF[DIGITS-1:0];
      digit_nib   <= 4'h0;
      digit_dp    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      digit_an    <= an_next;
      frame_start <= wrap && (idx_next == '0);
      if (wrap) begin
        digit_nib <= disp_val_next[{idx_next, 2'b00} +: 4];
        digit_dp  <= ~disp_dp_next[idx_next];
      end
    end
  end

endmodule

// File: tb/tb_io_seg7_scan.sv
// tb/tb_io_seg7_scan.sv - scoreboard bench for io_seg7_scan (DIGITS=4, CLK_DIV=8, DEAD=2)
module tb_io_seg7_scan;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 8;
  localparam int DEAD    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] val_in;
  logic        val_load;
  logic [3:0]  dp_in;
  logic        blank;
  logic [3:0]  digit_nib;
  logic [3:0]  digit_an;
  logic        digit_dp;
  logic        frame_start;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic [3:0] an;
  } exp_t;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  d;
    logic        b;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  io_seg7_scan #(
    .DIGITS  (DIGITS),
    .CLK_DIV (CLK_DIV),
    .DEAD    (DEAD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .val_in      (val_in),
    .val_load    (val_load),
    .dp_in       (dp_in),
    .blank       (blank),
    .digit_nib   (digit_nib),
    .digit_an    (digit_an),
    .digit_dp    (digit_dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    val_in   = v;
    dp_in    = d;
    val_load = 1'b1;
    @(negedge clk);
    val_load = 1'b0;
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fs_timeout", frame_start, 1);
  endtask

  // Expected per-slot results for one frame, derived from the value, dp mask and blank level.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic blk);
    for (int k = 0; k < DIGITS; k++) begin
      exp_t e;
      logic hid;
      hid = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
      hid = (k != 0) && !d[k] && ((v >> (4 * k)) == 16'h0);
`endif
      e.nib = v[4*k +: 4];
      e.dp  = ~d[k];
      e.an  = (blk || hid) ? 4'hF : ~(4'b0001 << k);
      sb.push_back(e);
    end
  endtask

  // Entered on the negedge where frame_start is high; returns at the next frame's first negedge.
  task automatic check_frame();
    for (int k = 0; k < DIGITS; k++) begin
      exp_t e;
      int   lowcnt;
      logic [3:0] an_seen;
      e = sb.pop_front();
      chk("fs", frame_start, (k == 0) ? 1 : 0);
      chk("nib", digit_nib, e.nib);
      chk("dp", digit_dp, e.dp);
      lowcnt  = 0;
      an_seen = 4'hF;
      for (int c = 0; c < CLK_DIV; c++) begin
        if (digit_an != 4'hF) begin
          lowcnt++;
          an_seen = digit_an;
        end
        if (c < DEAD) chk("an_dead", digit_an, 4'hF);
        @(negedge clk);
      end
      chk("an", an_seen, e.an);
      chk("an_low", lowcnt, (e.an == 4'hF) ? 0 : CLK_DIV - DEAD);
    end
  endtask

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] an_seen;

    tbl[0] = '{v: 16'h1234, d: 4'h0, b: 1'b0};
    tbl[1] = '{v: 16'hABCD, d: 4'h0, b: 1'b0};
    tbl[2] = '{v: 16'hABCD, d: 4'h0, b: 1'b1};
    tbl[3] = '{v: 16'h5678, d: 4'b0100, b: 1'b0};
    tbl[4] = '{v: 16'h0070, d: 4'h0, b: 1'b0};
    tbl[5] = '{v: 16'h0000, d: 4'h0, b: 1'b0};
    tbl[6] = '{v: 16'h0000, d: 4'b1000, b: 1'b0};

    reset    = 1'b1;
    val_in   = 16'h0;
    val_load = 1'b0;
    dp_in    = 4'h0;
    blank    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", digit_an, 4'hF);
    chk("rst_nib", digit_nib, 4'h0);
    chk("rst_dp", digit_dp, 1'b1);
    chk("rst_fs", frame_start, 1'b0);
    reset = 1'b0;

    load(tbl[0].v, tbl[0].d);
    wait_fs();

    // Each frame shows its own entry while the next entry is loaded mid-frame.
    for (int i = 0; i < 7; i++) begin
      blank = tbl[i].b;
      push_frame(tbl[i].v, tbl[i].d, tbl[i].b);
      fork
        check_frame();
        begin
          if (i < 6) begin
            repeat (10) @(negedge clk);
            load(tbl[i+1].v, tbl[i+1].d);
          end
        end
      join
    end
    blank = 1'b0;

    // Load coinciding with the frame boundary: old shadow shown one more frame.
    push_frame(tbl[6].v, tbl[6].d, 1'b0);
    fork
      check_frame();
      begin
        repeat (DIGITS * CLK_DIV - 1) @(negedge clk);
        load(16'h9E1F, 4'h0);
      end
    join
    push_frame(tbl[6].v, tbl[6].d, 1'b0);
    check_frame();
    push_frame(16'h9E1F, 4'h0, 1'b0);
    check_frame();

    // Reset during the SHOW phase of digit 2.
    repeat (2 * CLK_DIV + 3) @(negedge clk);
    chk("pre_rst_an", digit_an, 4'b1011);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", digit_an, 4'hF);
    chk("mid_rst_nib", digit_nib, 4'h0);
    chk("mid_rst_dp", digit_dp, 1'b1);
    chk("mid_rst_fs", frame_start, 1'b0);
    reset = 1'b0;
    an_seen = 4'hF;
    for (int c = 0; c < CLK_DIV; c++) begin
      @(negedge clk);
      if (an_seen == 4'hF && digit_an != 4'hF) an_seen = digit_an;
    end
    chk("restart_an", an_seen, 4'b1110);
    wait_fs();
    push_frame(16'h0000, 4'h0, 1'b0);
    check_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_seg7_scan.md
# io_seg7_scan

Time-multiplexed scanner for a common-anode seven-segment display bank. It latches a multi-digit hex value and cycles through the digits at a programmable refresh rate. For each active digit it presents one 4-bit nibble to the downstream seven-segment decoder and drives the matching digit-enable line, with a dead-time gap between digits to prevent ghosting. It sits between the status/debug logic that produces values and the combinational nibble-to-segment decoder.

## Interface
- DIGITS, 4, number of digits scanned (2..8)
- CLK_DIV, 50000, clk cycles per digit slot, including dead time (≥ DEAD+2)
- DEAD, 500, clk cycles at the start of each slot with all anodes off
- clk  in  1  system clock; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- val_in  in  4*DIGITS  hex value; digit 0 is val_in[3:0] (rightmost)
- val_load  in  1  single-cycle strobe; captures val_in and dp_in into the shadow register
- dp_in  in  DIGITS  per-digit decimal point request
- blank  in  1  level; forces all anodes off while high
- digit_nib  out  4  nibble for the decoder, registered
- digit_an  out  DIGITS  digit enables, active-low, registered, one-cold
- digit_dp  out  1  decimal point for the current digit, active-low, registered
- frame_start  out  1  one-cycle pulse when digit 0 slot begins

## Operation
- Two-stage buffering:
  - Shadow register (value + dp) loads on the cycle after val_load.
  - The display register copies the shadow at each frame boundary, i.e. at entry to digit 0. A frame therefore never mixes old and new digits.
- Prescaler counts 0..CLK_DIV-1 and wraps. At the wrap:
  - The digit index advances (DIGITS-1 wraps to 0).
  - The FSM enters DEAD.
- FSM states:
  - DEAD: all anodes high. Transitions to SHOW when prescaler == DEAD-1.
  - SHOW: anode[index] low, all others high. Transitions to DEAD at the prescaler wrap.
- digit_nib and digit_dp update on DEAD entry, so the nibble is stable through the whole dead time before the anode asserts.
- blank high: digit_an = all ones. The FSM, prescaler and index keep running, so the scan phase is unaffected.
- val_load during a frame: the shadow updates immediately. The display changes only at the next frame_start.
- val_load on the same cycle as a frame boundary: the display takes the previous shadow contents, and the new value appears at the following frame.
- Reset values:
  - prescaler 0, index 0, state DEAD
  - shadow and display registers 0
  - digit_an all ones, digit_nib 0, digit_dp 1, frame_start 0
- Reset mid-scan: all outputs return to reset values on the next edge. The first frame_start occurs on the first prescaler wrap after reset deasserts, when the index wraps to 0.

## Timing
- val_load to shadow: 1 cycle. Shadow to visible: up to DIGITS*CLK_DIV cycles.
- Digit slot period = CLK_DIV cycles. Anode low time = CLK_DIV-DEAD cycles.
- frame_start is high on the same cycle digit_nib first shows digit 0 data.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- SEG7_SCAN_LZB_EN defined: leading-zero blanking.
  - A digit whose nibble and all higher nibbles in the display register are 0 keeps its anode high in SHOW.
  - Digit 0 is never blanked.
  - A digit with its dp bit set is never blanked.
- SEG7_SCAN_LZB_EN undefined: every digit is displayed, and the blanking logic is absent.

## Structure
- Shared package io_seg7_pkg holds:
  - scan state enum (DEAD, SHOW)
  - localparam widths derived from DIGITS and CLK_DIV ($clog2)
  - all-off anode constant
- One sub-module, io_seg7_prescale: free-running divider. Outputs are the wrap pulse and the dead-end pulse.
- The nibble mux, FSM and buffering stay in io_seg7_scan.
- io_seg7_scan instantiates nothing downstream. The top level wires digit_nib to the decoder.

## Test plan
- Bench parameters: DIGITS=4, CLK_DIV=8, DEAD=2.
- Reset released, val_load with 0x1234 → after the next frame_start, digit_nib sequence 4,3,2,1 repeating every 32 cycles. Each anode is low for 6 cycles per slot.
- Load 0xABCD mid-frame → the remainder of the current frame still shows 1234 digits; 0xABCD appears starting at the next frame_start.
- blank high for 20 cycles → digit_an = 4'b1111 throughout. frame_start period stays 32 cycles.
- dp_in=4'b0100 → digit_dp low only during digit 2 slots.
- SEG7_SCAN_LZB_EN, value 0x0070 → digits 3 and 2 anodes stay high. Digit 1 (7) and digit 0 (0) are shown. Value 0x0000 → only digit 0 is shown.
- Assert reset during SHOW of digit 2 → next edge digit_an = all ones, digit_nib = 0. The scan restarts at digit 0.
